fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter sharing one synchronous FIFO write port between NUM_REQ producers.
- Each producer has a valid/ready handshake.
- The arbiter grants one producer at a time for a burst of up to MAX_BURST beats and drives the FIFO's write enable and data.
- Honours the FIFO full flag; sits directly in front of the FIFO write side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data width per requester and of the FIFO write data.
- MAX_BURST, 4, maximum beats granted per ownership (1..16).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  per-requester accept strobe.
- fifo_full  input  1  FIFO full flag.
- fifo_write_en  output  1  FIFO write enable.
- fifo_data_in  output  DATA_W  FIFO write data.
- grant_id  output  $clog2(NUM_REQ)  current owner index.
- busy  output  1  high while in BURST.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - Outputs while reset is low: fifo_write_en=0, req_ready=0, grant_id=0, busy=0, fifo_data_in=0.
  - Reset asserted mid-burst aborts the burst immediately; no partial beat is written.
- States: IDLE, BURST.
- IDLE:
  - No ready, no write enable.
  - If any req_valid is high, the winner is the first valid index at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
  - Next edge: owner<=winner, beat_cnt<=0, state<=BURST.
  - Arbitration latency is 1 cycle: the first beat can occur no earlier than the cycle after the request is seen.
- BURST outputs (combinational from registered state and inputs):
  - req_ready[i] = (i==owner) && !fifo_full.
  - fifo_write_en = req_valid[owner] && !fifo_full.
  - fifo_data_in = req_data slice of owner.
  - grant_id = owner; busy = 1.
- Beat: cycle in which req_valid[owner] && req_ready[owner]. The FIFO captures the data on that edge. beat_cnt increments by 1 per beat.
- Release: return to IDLE and set rr_ptr<=(owner+1) mod NUM_REQ when either condition holds:
  - a beat occurs with beat_cnt==MAX_BURST-1, or
  - req_valid[owner] is low in any BURST cycle, whether or not fifo_full is high.
- fifo_full high in BURST: no beat, beat_cnt holds, ownership held indefinitely while req_valid[owner] stays high.
- After a release there is at least one IDLE cycle before the next grant (no back-to-back grant).
- Non-owner requesters always see req_ready=0 and must hold valid and data stable until accepted.
- Requests from requesters that are not the owner are ignored in BURST; they are arbitrated at the next IDLE.
- Index arithmetic wraps modulo NUM_REQ. beat_cnt is $clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST-1.
- fifo_data_in outside BURST is 0.

Optional Feature:
- Macro: FIFO_ARB_PRIO0_EN.
- Defined:
  - Requester 0 wins IDLE arbitration whenever req_valid[0] is high, regardless of rr_ptr.
  - rr_ptr is not updated when owner 0 releases.
  - All other requesters remain round-robin among themselves.
- Undefined: pure round-robin as in Behaviour, with no priority logic synthesised.

Test Plan:
- Reset: drive reset low mid-burst with req_valid=4'b1111 -> all outputs 0 within the same cycle; after release of reset, first grant goes to requester 0 with busy high one cycle after IDLE sees valid.
- Round-robin: req_valid=4'b1111 held, each requester streams data 8'hA0+i -> bursts of exactly 4 beats in order 0,1,2,3,0, one IDLE cycle between bursts, FIFO receives A0 x4, A1 x4, A2 x4, A3 x4.
- Early release: only requester 2 valid for 2 beats then drops -> 2 writes, IDLE next cycle, rr_ptr=3; a then-valid requester 1 is granted next.
- Full stall: during requester 1 burst, hold fifo_full high 5 cycles after beat 2 -> fifo_write_en=0 and req_ready=0 for 5 cycles, beat_cnt stays 2, burst completes with beats 3 and 4 after full drops.
- Valid drop while full: owner drops req_valid while fifo_full=1 -> release to IDLE next edge, no write.
- FIFO_ARB_PRIO0_EN defined: req_valid=4'b1110 with owner 1 mid-burst, req_valid[0] rises -> after owner 1 releases, requester 0 is granted next, not requester 2.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Optional: define FIFO_ARB_PRIO0_EN to give requester 0 fixed priority in IDLE arbitration.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_write_en,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;

  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   owner_next;
  logic              owner_valid;
  logic              beat;
  logic              last_beat;

  always_comb begin
    owner_valid = req_valid[owner];
    beat        = (state == BURST) && owner_valid && !fifo_full;
    last_beat   = (beat_cnt == CNT_W'(MAX_BURST - 1));
    owner_next  = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
  end

  // Scan from the farthest candidate back toward rr_ptr so the nearest valid one wins.
  always_comb begin
    int unsigned pos;
    pos    = 0;
    winner = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      pos = 32'(rr_ptr) + (NUM_REQ - 1 - j);
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req_valid[ID_W'(pos)]) winner = ID_W'(pos);
    end
`ifdef FIFO_ARB_PRIO0_EN
    if (req_valid[0]) winner = '0;
`endif
  end

  always_comb begin
    req_ready     = '0;
    fifo_write_en = 1'b0;
    fifo_data_in  = '0;
    grant_id      = '0;
    busy          = 1'b0;
    if (state == BURST) begin
      req_ready     = fifo_full ? '0 : (NUM_REQ'(1) << owner);
      fifo_write_en = beat;
      fifo_data_in  = DATA_W'(req_data >> (32'(owner) * DATA_W));
      grant_id      = owner;
      busy          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner    <= winner;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (!owner_valid || (beat && last_beat)) begin
            state    <= IDLE;
            beat_cnt <= '0;
`ifdef FIFO_ARB_PRIO0_EN
            if (owner != '0) rr_ptr <= owner_next;
`else
            rr_ptr   <= owner_next;
`endif
          end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus queues expected {grant_id, data} writes,
// a negedge monitor pops one per FIFO write. Expectations target the default (no priority) build.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_write_en;
  logic [7:0]  fifo_data_in;
  logic [1:0]  grant_id;
  logic        busy;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;
  int unsigned cyc_start;
  logic [9:0]  exp_q[$];
  logic [9:0]  exp_e;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every FIFO write must match the next expected {owner, data}.
  always @(negedge clk) begin
    if (reset && fifo_write_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got id=%0d data=%h, expected no write", grant_id, fifo_data_in);
      end else begin
        exp_e = exp_q.pop_front();
        if ({grant_id, fifo_data_in} !== exp_e || req_ready !== (4'b0001 << exp_e[9:8])) begin
          n_fail++;
          $display("FAIL write: got id=%0d data=%h ready=%b, expected id=%0d data=%h ready=%b",
                   grant_id, fifo_data_in, req_ready, exp_e[9:8], exp_e[7:0], 4'b0001 << exp_e[9:8]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    req_data[i*8 +: 8] = d;
  endtask

  task automatic push(input logic [7:0] d, input int id, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({2'(id), d});
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (exp_q.size() != 0 && n < 200);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d writes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic all_data();
    for (int i = 0; i < 4; i++) set_data(i, 8'hA0 + 8'(i));
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    #2;
    req_valid = 4'b1111; all_data();
    #1;
    check("rst_we",   fifo_write_en, 0);
    check("rst_rdy",  req_ready,     0);
    check("rst_busy", busy,          0);
    check("rst_gid",  grant_id,      0);
    check("rst_data", fifo_data_in,  0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Round robin: five full bursts 0,1,2,3,0 with one IDLE cycle between each.
    tick();
    cyc_start = cyc;
    req_valid = 4'b1111; all_data();
    for (int b = 0; b < 5; b++) push(8'hA0 + 8'(b % 4), b % 4, 4);
    #1 check("rr_idle_busy", busy, 0);
    tick();
    check("rr_grant_busy", busy, 1);
    check("rr_grant_id", grant_id, 0);
    drain();
    tick();
    check("rr_cycles", cyc - cyc_start, 25);
    check("rr_end_idle", busy, 0);
    req_valid = '0;

    // Early release: requester 2 sends 2 beats then drops; requester 1 granted next.
    tick();
    req_valid = 4'b0100; set_data(2, 8'h21); push(8'h21, 2, 1);
    tick();
    tick();
    set_data(2, 8'h22); push(8'h22, 2, 1);
    tick();
    req_valid = 4'b0010; set_data(1, 8'h31);
    tick();
    check("er_idle", busy, 0);
    push(8'h31, 1, 1);
    tick();
    check("er_grant_busy", busy, 1);
    check("er_grant_id", grant_id, 1);

    // Full stall after beat 2 of requester 1's burst, then beats 3 and 4.
    tick();
    set_data(1, 8'h32); push(8'h32, 1, 1);
    tick();
    fifo_full = 1'b1; set_data(1, 8'h33);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("fs_we",   fifo_write_en, 0);
      check("fs_rdy",  req_ready,     0);
      check("fs_busy", busy,          1);
      tick();
    end
    fifo_full = 1'b0; push(8'h33, 1, 1);
    tick();
    set_data(1, 8'h34); push(8'h34, 1, 1);
    tick();
    check("fs_release", busy, 0);
    check("fs_all_written", exp_q.size(), 0);
    req_valid = '0;

    // Owner drops valid while the FIFO is full: release with no write.
    tick();
    req_valid = 4'b0001; set_data(0, 8'h51); fifo_full = 1'b1;
    tick();
    #1;
    check("vd_busy", busy, 1);
    check("vd_gid",  grant_id, 0);
    check("vd_we",   fifo_write_en, 0);
    tick();
    req_valid = '0;
    tick();
    check("vd_release", busy, 0);
    fifo_full = 1'b0;

    // Reset mid-burst: outputs clear at once, then requester 0 wins after reset.
    tick();
    req_valid = 4'b1111; all_data(); push(8'hA1, 1, 1);
    tick();
    check("mr_gid", grant_id, 1);
    tick();
    reset = 1'b0;
    #1;
    check("mr_we",   fifo_write_en, 0);
    check("mr_rdy",  req_ready,     0);
    check("mr_busy", busy,          0);
    check("mr_gid0", grant_id,      0);
    check("mr_data", fifo_data_in,  0);
    repeat (2) tick();
    reset = 1'b1;
    push(8'hA0, 0, 4);
    #1 check("mr_idle", busy, 0);
    tick();
    check("mr_regrant_busy", busy, 1);
    check("mr_regrant_id", grant_id, 0);
    drain();
    tick();
    req_valid = '0;
    check("mr_end_idle", busy, 0);

    // Requester 0 rises during requester 1's burst; next owner depends on priority build.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    req_valid = 4'b1110; all_data(); push(8'hA1, 1, 4);
    tick();
    check("pr_gid1", grant_id, 1);
    tick();
    req_valid = 4'b1111;
    drain();
    tick();
    check("pr_gap", busy, 0);
    tick();
    check("pr_next_busy", busy, 1);
`ifdef FIFO_ARB_PRIO0_EN
    check("pr_next_id", grant_id, 0);
    push(8'hA0, 0, 4);
`else
    check("pr_next_id", grant_id, 2);
    push(8'hA2, 2, 4);
`endif
    drain();
    tick();
    req_valid = '0;
    check("pr_end_idle", busy, 0);

    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
